// File: rtl/definitions.sv
// Shared types and defaults for the instruction fetch path.
package definitions;
    typedef enum logic [1:0] {FS_IDLE, FS_RUN, FS_HALTED} fetch_state_t;

    localparam int PC_W_DEF     = 10;
    localparam int LBL_W        = 4;
    localparam int N_LABELS_DEF = 16;
    localparam int CNT_W_DEF    = 16;
endpackage

// File: rtl/label_lut.sv
// Branch label table: maps a label index to an absolute PC.
// Reads are combinational, so a same-cycle write is not visible until the next cycle.
module label_lut #(
    parameter int N_LABELS = 16,
    parameter int PC_W     = 10,
    parameter int IDX_W    = $clog2(N_LABELS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             WrEn,
    input  logic [IDX_W-1:0] WrIdx,
    input  logic [PC_W-1:0]  WrAddr,
    input  logic [IDX_W-1:0] RdIdx,
    output logic [PC_W-1:0]  RdAddr
);
    logic [N_LABELS-1:0][PC_W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (WrEn) mem_d[WrIdx] = WrAddr;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) mem_q <= '0;
        else        mem_q <= mem_d;
    end

    assign RdAddr = mem_q[RdIdx];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, IDLE/RUN/HALTED sequencing and retired-instruction counter.
// Branch targets come from the label table; Halt takes priority over BranchEn.
module fetch_unit
    import definitions::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int N_LABELS = N_LABELS_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int IDX_W    = $clog2(N_LABELS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             BranchEn,
    input  logic [IDX_W-1:0] label_index,
    input  logic             Halt,
    input  logic             LutWrEn,
    input  logic [IDX_W-1:0] LutWrIdx,
    input  logic [PC_W-1:0]  LutWrAddr,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             FetchValid,
    output logic             Done,
    output logic [CNT_W-1:0] InstrCount
);
    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             done_q, done_d;
    logic [PC_W-1:0]  lut_target;

    label_lut #(.N_LABELS(N_LABELS), .PC_W(PC_W), .IDX_W(IDX_W)) u_lut (
        .Clk    (Clk),
        .Reset  (Reset),
        .WrEn   (LutWrEn),
        .WrIdx  (LutWrIdx),
        .WrAddr (LutWrAddr),
        .RdIdx  (label_index),
        .RdAddr (lut_target)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FS_IDLE, FS_HALTED: begin
                if (Start) begin
                    pc_d    = '0;
                    cnt_d   = '0;
                    state_d = FS_RUN;
                end
            end
            FS_RUN: begin
                // Every RUN cycle retires one instruction; counter sticks at all-ones.
                cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                if (Halt)          state_d = FS_HALTED;
                else if (BranchEn) pc_d    = lut_target;
                else               pc_d    = pc_q + PC_W'(1);
            end
            default: state_d = FS_IDLE;
        endcase
        fetch_valid_d = (state_d == FS_RUN);
        done_d        = (state_d == FS_HALTED);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= FS_IDLE;
            pc_q          <= '0;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= fetch_valid_d;
            done_q        <= done_d;
        end
    end

    assign ProgCtr    = pc_q;
    assign FetchValid = fetch_valid_q;
    assign Done       = done_q;
    assign InstrCount = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; counter narrowed to 4 bits so saturation is reachable.
module tb_fetch_unit;
    localparam int PC_W  = 10;
    localparam int CNT_W = 4;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic             Start = 1'b0;
    logic             BranchEn = 1'b0;
    logic [3:0]       label_index = '0;
    logic             Halt = 1'b0;
    logic             LutWrEn = 1'b0;
    logic [3:0]       LutWrIdx = '0;
    logic [PC_W-1:0]  LutWrAddr = '0;
    logic [PC_W-1:0]  ProgCtr;
    logic             FetchValid;
    logic             Done;
    logic [CNT_W-1:0] InstrCount;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.PC_W(PC_W), .N_LABELS(16), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .BranchEn(BranchEn),
        .label_index(label_index), .Halt(Halt), .LutWrEn(LutWrEn),
        .LutWrIdx(LutWrIdx), .LutWrAddr(LutWrAddr), .ProgCtr(ProgCtr),
        .FetchValid(FetchValid), .Done(Done), .InstrCount(InstrCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_pc", 32'(ProgCtr), 0);
        chk("rst_fv", 32'(FetchValid), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_cnt", 32'(InstrCount), 0);
        step();
        Reset = 1'b1;
        step();

        // 1: five straight-line instructions then Halt at PC 5
        Start = 1'b1; step(); Start = 1'b0;
        chk("t1_fv", 32'(FetchValid), 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t1_pc%0d", i), 32'(ProgCtr), 32'(i));
            step();
        end
        chk("t1_pc5", 32'(ProgCtr), 5);
        Halt = 1'b1; step(); Halt = 1'b0;
        chk("t1_done", 32'(Done), 1);
        chk("t1_fv_off", 32'(FetchValid), 0);
        chk("t1_pc_hold", 32'(ProgCtr), 5);
        chk("t1_cnt", 32'(InstrCount), 6);
        step();
        chk("t1_pc_hold2", 32'(ProgCtr), 5);
        chk("t1_cnt_hold", 32'(InstrCount), 6);

        // 2: lut[3]=0x040, branch at PC 2
        LutWrEn = 1'b1; LutWrIdx = 4'd3; LutWrAddr = 10'h040; step(); LutWrEn = 1'b0;
        Start = 1'b1; step(); Start = 1'b0;
        chk("t2_restart_pc", 32'(ProgCtr), 0);
        chk("t2_restart_cnt", 32'(InstrCount), 0);
        step(2);
        chk("t2_pc2", 32'(ProgCtr), 2);
        BranchEn = 1'b1; label_index = 4'd3; step(); BranchEn = 1'b0;
        chk("t2_br", 32'(ProgCtr), 32'h040);
        step();
        chk("t2_br_next", 32'(ProgCtr), 32'h041);
        Halt = 1'b1; step(); Halt = 1'b0;

        // 3: Halt and BranchEn together at PC 7
        Start = 1'b1; step(); Start = 1'b0;
        step(7);
        chk("t3_pc7", 32'(ProgCtr), 7);
        Halt = 1'b1; BranchEn = 1'b1; label_index = 4'd3; step();
        Halt = 1'b0; BranchEn = 1'b0;
        chk("t3_pc", 32'(ProgCtr), 7);
        chk("t3_done", 32'(Done), 1);
        chk("t3_cnt", 32'(InstrCount), 8);

        // 4: write and branch to label 3 in the same cycle uses the old entry
        Start = 1'b1; step(); Start = 1'b0;
        LutWrEn = 1'b1; LutWrIdx = 4'd3; LutWrAddr = 10'h100;
        BranchEn = 1'b1; label_index = 4'd3; step();
        LutWrEn = 1'b0;
        chk("t4_old", 32'(ProgCtr), 32'h040);
        step();
        chk("t4_new", 32'(ProgCtr), 32'h100);
        BranchEn = 1'b0;

        // 5: wrap from 0x3FF, then counter saturation
        LutWrEn = 1'b1; LutWrIdx = 4'd5; LutWrAddr = 10'h3FF; step(); LutWrEn = 1'b0;
        chk("t5_fall", 32'(ProgCtr), 32'h101);
        BranchEn = 1'b1; label_index = 4'd5; step(); BranchEn = 1'b0;
        chk("t5_top", 32'(ProgCtr), 32'h3FF);
        step();
        chk("t5_wrap", 32'(ProgCtr), 0);
        chk("t5_cnt", 32'(InstrCount), 5);
        step(12);
        chk("t5_sat", 32'(InstrCount), 15);
        chk("t5_pc", 32'(ProgCtr), 12);

        // Reset back to IDLE, then pulse decoder outputs there
        Reset = 1'b0; #1;
        chk("rst2_pc", 32'(ProgCtr), 0);
        chk("rst2_fv", 32'(FetchValid), 0);
        chk("rst2_cnt", 32'(InstrCount), 0);
        step(); Reset = 1'b1; step();
        Halt = 1'b1; BranchEn = 1'b1; label_index = 4'd5; step();
        Halt = 1'b0; BranchEn = 1'b0;
        chk("t5_idle_pc", 32'(ProgCtr), 0);
        chk("t5_idle_fv", 32'(FetchValid), 0);
        chk("t5_idle_done", 32'(Done), 0);
        step(); Start = 1'b1; step(); Start = 1'b0;
        BranchEn = 1'b1; label_index = 4'd5; step(); BranchEn = 1'b0;
        chk("t5_lut_clr", 32'(ProgCtr), 0);

        // 6: asynchronous reset mid-RUN at PC 9
        step(9);
        chk("t6_pc9", 32'(ProgCtr), 9);
        #2 Reset = 1'b0; #1;
        chk("t6_async_pc", 32'(ProgCtr), 0);
        chk("t6_async_fv", 32'(FetchValid), 0);
        chk("t6_async_done", 32'(Done), 0);
        step(); Reset = 1'b1; step();
        Start = 1'b1; step(); Start = 1'b0;
        BranchEn = 1'b1; label_index = 4'd3; step(); BranchEn = 1'b0;
        chk("t6_lut_clr", 32'(ProgCtr), 0);
        Halt = 1'b1; step(); Halt = 1'b0;
        chk("t6_halt_cnt", 32'(InstrCount), 2);
        Start = 1'b1; step(); Start = 1'b0;
        chk("t6_restart_pc", 32'(ProgCtr), 0);
        chk("t6_restart_cnt", 32'(InstrCount), 0);
        chk("t6_restart_fv", 32'(FetchValid), 1);
        step();
        chk("t6_run_pc", 32'(ProgCtr), 1);
        chk("t6_run_cnt", 32'(InstrCount), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
